// File: rtl/out_flow_demux_if.sv
// out_flow_demux_if: tagged pixel input, flow configuration and per-flow FIFO output bundle.
interface out_flow_demux_if #(
  parameter int FLUX = 4,
  parameter int DW = 8
);
  localparam int TW = $clog2(FLUX);
  logic [TW+DW-1:0] in_din;
  logic in_write;
  logic [FLUX-1:0] in_full;
  logic [TW+12:0] cfg_din;
  logic cfg_write;
  logic [FLUX*DW-1:0] out_dout;
  logic [FLUX-1:0] out_empty;
  logic [FLUX-1:0] out_read;
  logic [FLUX-1:0] done;
  logic err;
  modport master (
    output in_din, in_write, cfg_din, cfg_write, out_read,
    input in_full, out_dout, out_empty, done, err
  );
  modport slave (
    input in_din, in_write, cfg_din, cfg_write, out_read,
    output in_full, out_dout, out_empty, done, err
  );
endinterface

// File: rtl/out_flow_demux.sv
// out_flow_demux: routes tagged pixels into per-flow FWFT FIFOs and pulses done when a configured frame completes.
// Optional sticky error detection is enabled by defining OUT_FLOW_DEMUX_ERR_EN.
module out_flow_demux #(
  parameter int FLUX = 4,
  parameter int DEPTH = 16,
  parameter int DW = 8
) (
  input logic clk,
  input logic rst,
  out_flow_demux_if.slave bus
);
  localparam int TW = $clog2(FLUX);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, ARMED} state_t;
  logic [TW-1:0] in_tag, cfg_tag;
  logic [DW-1:0] pixel;
  logic [12:0] cfg_size;
  logic [FLUX-1:0] full, empty, armed, done_q;
  logic [DW-1:0] head [FLUX];
  assign in_tag = bus.in_din[TW+DW-1:DW];
  assign pixel = bus.in_din[DW-1:0];
  assign cfg_tag = bus.cfg_din[TW+12:13];
  assign cfg_size = bus.cfg_din[12:0];
  for (genvar f = 0; f < FLUX; f++) begin : g_flow
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] occ;
    logic [12:0] target, count;
    logic wr_acc, rd_acc, cfg_hit, done_r;
    state_t st;
    assign full[f] = occ == (AW+1)'(DEPTH);
    assign empty[f] = occ == '0;
    assign armed[f] = st == ARMED;
    assign done_q[f] = done_r;
    assign wr_acc = bus.in_write && !rst && in_tag == TW'(f) && !full[f];
    assign rd_acc = bus.out_read[f] && !rst && !empty[f];
    assign cfg_hit = bus.cfg_write && !rst && cfg_tag == TW'(f);
    assign head[f] = (empty[f] || rst) ? '0 : mem[rp];
    always_ff @(posedge clk)
      if (wr_acc) mem[wp] <= pixel;
    // cfg takes priority over counting; the pixel is still buffered by the FIFO path
    always_ff @(posedge clk)
      if (rst) begin
        wp <= '0;
        rp <= '0;
        occ <= '0;
        st <= IDLE;
        target <= '0;
        count <= '0;
        done_r <= 1'b0;
      end else begin
        if (wr_acc) wp <= wp + 1'b1;
        if (rd_acc) rp <= rp + 1'b1;
        occ <= occ + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
        done_r <= 1'b0;
        if (cfg_hit) begin
          st <= cfg_size != '0 ? ARMED : IDLE;
          target <= cfg_size;
          count <= '0;
        end else if (wr_acc && st == ARMED) begin
          if (count + 13'd1 == target) begin
            done_r <= 1'b1;
            st <= IDLE;
            count <= '0;
          end else count <= count + 13'd1;
        end
      end
  end
  always_comb begin
    bus.out_dout = '0;
    for (int i = 0; i < FLUX; i++) bus.out_dout[i*DW +: DW] = head[i];
  end
  assign bus.in_full = rst ? '0 : full;
  assign bus.out_empty = rst ? '1 : empty;
  assign bus.done = rst ? '0 : done_q;
`ifdef OUT_FLOW_DEMUX_ERR_EN
  logic err_q, err_ev;
  assign err_ev = (bus.in_write && (full[in_tag] || !armed[in_tag])) || |(bus.out_read & empty);
  always_ff @(posedge clk)
    if (rst) err_q <= 1'b0;
    else if (err_ev) err_q <= 1'b1;
  assign bus.err = err_q && !rst;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_out_flow_demux.sv
// tb_out_flow_demux: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_out_flow_demux;
  localparam int FLUX = 4;
  localparam int DEPTH = 16;
  localparam int DW = 8;
  localparam int TW = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  out_flow_demux_if #(.FLUX(FLUX), .DW(DW)) bus ();
  out_flow_demux #(.FLUX(FLUX), .DEPTH(DEPTH), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_tests = 0;
  int n_fail = 0;
  logic [DW-1:0] q [FLUX][$];
  bit m_armed [FLUX];
  int m_target [FLUX];
  int m_count [FLUX];
  logic [FLUX-1:0] m_done;
  logic m_err;
  typedef struct {
    logic w;
    int tag;
    int pix;
    logic cw;
    int ctag;
    int csize;
    logic [3:0] rd;
    logic [3:0] exp_empty;
    logic [3:0] exp_done;
    logic [7:0] exp_head0;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic w, input int tag, input int pix, input logic cw, input int ctag,
                       input int csize, input logic [FLUX-1:0] rd, input logic r);
    bus.in_write = w;
    bus.in_din = {tag[TW-1:0], pix[DW-1:0]};
    bus.cfg_write = cw;
    bus.cfg_din = {ctag[TW-1:0], csize[12:0]};
    bus.out_read = rd;
    rst = r;
  endtask

  task automatic model();
    int tag, ctag, csize;
    logic [FLUX-1:0] fullp;
    bit acc;
    if (rst) begin
      for (int f = 0; f < FLUX; f++) begin
        q[f].delete();
        m_armed[f] = 0;
        m_target[f] = 0;
        m_count[f] = 0;
      end
      m_done = '0;
      m_err = 1'b0;
      return;
    end
    tag = int'(bus.in_din[TW+DW-1:DW]);
    ctag = int'(bus.cfg_din[TW+12:13]);
    csize = int'(bus.cfg_din[12:0]);
    for (int f = 0; f < FLUX; f++) fullp[f] = q[f].size() == DEPTH;
    if (bus.in_write && (fullp[tag] || !m_armed[tag])) m_err = 1'b1;
    for (int f = 0; f < FLUX; f++) if (bus.out_read[f] && q[f].size() == 0) m_err = 1'b1;
    m_done = '0;
    for (int f = 0; f < FLUX; f++) if (bus.out_read[f] && q[f].size() > 0) void'(q[f].pop_front());
    acc = bus.in_write && !fullp[tag];
    if (acc) q[tag].push_back(bus.in_din[DW-1:0]);
    if (bus.cfg_write) begin
      m_armed[ctag] = csize != 0;
      m_target[ctag] = csize;
      m_count[ctag] = 0;
    end
    if (acc && !(bus.cfg_write && ctag == tag) && m_armed[tag]) begin
      m_count[tag]++;
      if (m_count[tag] == m_target[tag]) begin
        m_done[tag] = 1'b1;
        m_armed[tag] = 0;
        m_count[tag] = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [FLUX-1:0] e_empty, e_full;
    logic [FLUX*DW-1:0] e_dout;
    logic e_err;
    e_dout = '0;
    for (int f = 0; f < FLUX; f++) begin
      e_empty[f] = q[f].size() == 0;
      e_full[f] = q[f].size() == DEPTH;
      if (q[f].size() > 0) e_dout[f*DW +: DW] = q[f][0];
    end
`ifdef OUT_FLOW_DEMUX_ERR_EN
    e_err = m_err;
`else
    e_err = 1'b0;
`endif
    chk("out_empty", 32'(bus.out_empty), 32'(e_empty));
    chk("in_full", 32'(bus.in_full), 32'(e_full));
    chk("out_dout", 32'(bus.out_dout), 32'(e_dout));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("err", 32'(bus.err), 32'(e_err));
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input logic r);
    drive(0, 0, 0, 0, 0, 0, '0, r);
    step();
  endtask

  task automatic wr(input int tag, input int pix);
    drive(1, tag, pix, 0, 0, 0, '0, 0);
    step();
  endtask

  task automatic cfg(input int tag, input int size);
    drive(0, 0, 0, 1, tag, size, '0, 0);
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH && bus.out_empty != '1; i++) begin
      drive(0, 0, 0, 0, 0, 0, ~bus.out_empty, 0);
      step();
    end
    chk("drain_empty", 32'(bus.out_empty), 32'hf);
  endtask

  task automatic pop_count(input int f, output int n);
    n = 0;
    for (int i = 0; i < 3 * DEPTH && !bus.out_empty[f]; i++) begin
      drive(0, 0, 0, 0, 0, 0, FLUX'(1) << f, 0);
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    logic [FLUX-1:0] rd;
    tbl[0] = '{0, 0, 0, 1, 0, 4, 4'h0, 4'hf, 4'h0, 8'h00};
    tbl[1] = '{1, 0, 8'h11, 0, 0, 0, 4'h0, 4'he, 4'h0, 8'h11};
    tbl[2] = '{1, 0, 8'h12, 0, 0, 0, 4'h0, 4'he, 4'h0, 8'h11};
    tbl[3] = '{1, 0, 8'h13, 0, 0, 0, 4'h0, 4'he, 4'h0, 8'h11};
    tbl[4] = '{1, 0, 8'h14, 0, 0, 0, 4'h0, 4'he, 4'h1, 8'h11};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 4'h1, 4'he, 4'h0, 8'h12};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 4'h1, 4'he, 4'h0, 8'h13};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 4'h1, 4'he, 4'h0, 8'h14};
    tbl[8] = '{0, 0, 0, 0, 0, 0, 4'h1, 4'hf, 4'h0, 8'h00};
    tbl[9] = '{0, 0, 0, 0, 0, 0, 4'h1, 4'hf, 4'h0, 8'h00};
    idle(1);
    idle(1);
    chk("reset_empty", 32'(bus.out_empty), 32'hf);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].w, tbl[i].tag, tbl[i].pix, tbl[i].cw, tbl[i].ctag, tbl[i].csize, tbl[i].rd, 0);
      step();
      chk($sformatf("tbl%0d_empty", i), 32'(bus.out_empty), 32'(tbl[i].exp_empty));
      chk($sformatf("tbl%0d_done", i), 32'(bus.done), 32'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_head0", i), 32'(bus.out_dout[7:0]), 32'(tbl[i].exp_head0));
    end
    idle(1);
    for (int i = 0; i < 17; i++) begin
      wr(2, 8'h40 + i);
      if (i == 15) chk("full2_after16", 32'(bus.in_full[2]), 32'h1);
    end
    pop_count(2, n);
    chk("pop2_count", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) wr(1, 8'h60 + i);
    chk("full1", 32'(bus.in_full[1]), 32'h1);
    drive(1, 1, 8'hee, 0, 0, 0, 4'b0010, 0);
    step();
    chk("full1_after_rw", 32'(bus.in_full[1]), 32'h0);
    pop_count(1, n);
    chk("pop1_count", 32'(n), 32'd15);
    idle(1);
    cfg(3, 2);
    cfg(0, 2);
    wr(3, 8'ha1);
    chk("il_done_a", 32'(bus.done), 32'h0);
    wr(0, 8'hb1);
    chk("il_done_b", 32'(bus.done), 32'h0);
    wr(3, 8'ha2);
    chk("il_done3", 32'(bus.done), 32'h8);
    wr(0, 8'hb2);
    chk("il_done0", 32'(bus.done), 32'h1);
    drain();
    idle(1);
    cfg(0, 8);
    for (int i = 0; i < 3; i++) wr(0, 8'h20 + i);
    idle(1);
    chk("rst_mid_empty", 32'(bus.out_empty), 32'hf);
    chk("rst_mid_done", 32'(bus.done), 32'h0);
    for (int i = 0; i < 8; i++) wr(0, 8'h30 + i);
    chk("idle_no_done", 32'(bus.done), 32'h0);
    drain();
    idle(1);
    cfg(1, 5);
    wr(1, 8'h01);
    wr(1, 8'h02);
    cfg(1, 5);
    for (int i = 0; i < 4; i++) begin
      wr(1, 8'h03 + i);
      chk("recfg_no_done", 32'(bus.done), 32'h0);
    end
    wr(1, 8'h07);
    chk("recfg_done", 32'(bus.done), 32'h2);
    drain();
    for (int i = 0; i < 3000; i++) begin
      rd = FLUX'($urandom_range(0, 15) & $urandom_range(0, 15));
      if ((i % 500) < 250) rd = rd & FLUX'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), $urandom_range(0, FLUX - 1), $urandom_range(0, 255),
            $urandom_range(0, 5) == 0, $urandom_range(0, FLUX - 1), $urandom_range(0, 5),
            rd, $urandom_range(0, 299) == 0);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/out_flow_demux.md
OUT_FLOW_DEMUX -- requirements
Module: out_flow_demux

Interface
REQ-001 Parameter FLUX, default 4: number of flows; tag width TW = clog2(FLUX).
REQ-002 Parameter DEPTH, default 16: per-flow FIFO depth in words, a power of 2 and at least 2.
REQ-003 Parameter DW, default 8: pixel width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_din  in  TW+DW  tagged pixel from the filter output port, tag in [TW+DW-1:DW] and pixel in [DW-1:0].
REQ-007 in_write  in  1  in_din valid this cycle.
REQ-008 in_full  out  FLUX  per-flow backpressure; bit f high means a write tagged f is not accepted.
REQ-009 cfg_din  in  TW+13  {tag, frame_size[12:0]}, where frame_size is the expected pixel count (max 4096).
REQ-010 cfg_write  in  1  cfg_din valid.
REQ-011 out_dout  out  FLUX*DW  per-flow FIFO head, flow f in bits [f*DW+DW-1:f*DW].
REQ-012 out_empty  out  FLUX  per-flow FIFO empty.
REQ-013 out_read  in  FLUX  per-flow pop request.
REQ-014 done  out  FLUX  one-cycle pulse per flow at frame completion.
REQ-015 err  out  1  sticky error flag (see Configuration).

Function
REQ-016 Each flow SHALL own one FIFO of DEPTH words with first-word-fall-through behaviour: out_dout[f] SHALL be valid whenever out_empty[f] is low.
REQ-017 A write SHALL be accepted when in_write=1 and in_full[tag]=0; the pixel SHALL enter only FIFO[tag].
REQ-018 in_full[f] SHALL be high iff occupancy[f]==DEPTH, taken from the registered value at the start of the cycle. A write to a full FIFO SHALL be dropped, even if out_read[f] is asserted in the same cycle.
REQ-019 A pixel accepted at edge N SHALL drive out_empty[f]=0 and appear on out_dout[f] from edge N onward. Latency is 1 cycle.
REQ-020 out_read[f] with out_empty[f]=1 SHALL be ignored.
REQ-021 Simultaneous accepted write and read on the same non-empty FIFO SHALL leave occupancy unchanged.
REQ-022 FIFO read and write pointers SHALL wrap modulo DEPTH. Occupancy SHALL span 0..DEPTH inclusive.
REQ-023 Per-flow state: IDLE (unarmed) or ARMED(target, count).
REQ-024 cfg_write with nonzero frame_size SHALL set flow[tag] to ARMED with count=0 and target=frame_size. This SHALL apply even if the flow is already ARMED mid-frame; that frame is abandoned and done is not pulsed.
REQ-025 cfg_write with frame_size=0 SHALL return flow[tag] to IDLE.
REQ-026 Each accepted write to an ARMED flow SHALL increment count by 1.
REQ-027 When count+1==target on an accepted write, done[tag] SHALL pulse high in the cycle after that edge. The flow SHALL then return to IDLE with count=0.
REQ-028 Accepted writes to an IDLE flow SHALL still be buffered but SHALL NOT be counted.
REQ-029 cfg_write and an accepted write to the same flow in the same cycle: cfg SHALL win, the pixel SHALL be buffered, and count SHALL be 0 after the edge.
REQ-030 Different flows SHALL be fully independent: FIFOs, counters and done pulses never interact.

Reset
REQ-031 On rst=1 at an edge, all FIFOs SHALL empty, with pointers and occupancy set to 0.
REQ-032 On the same edge, all flows SHALL go to IDLE with count=0 and target=0.
REQ-033 Output values while in reset: out_empty all 1s, in_full 0, done 0, err 0, out_dout 0.
REQ-034 Reset mid-frame SHALL discard buffered data. No done pulse SHALL be produced for the interrupted frame.
REQ-035 in_write, cfg_write and out_read SHALL be ignored while rst=1.

Configuration
REQ-036 Macro OUT_FLOW_DEMUX_ERR_EN controls error detection.
REQ-037 When defined, err SHALL set to 1 and stay set until rst on any of these events:
- in_write to a full flow;
- in_write to an IDLE flow;
- out_read to an empty flow.
REQ-038 When undefined, err SHALL be tied to 0, and those events SHALL only be dropped or ignored as specified above.

Verification
REQ-039 cfg flow0 size 4; write 4 pixels 0x11..0x14 tag 0 over 4 consecutive cycles -> done[0] pulses once, one cycle after the 4th edge; FIFO0 pops 0x11,0x12,0x13,0x14; other flows stay empty.
REQ-040 Write 17 pixels tag 2, no reads (DEPTH=16) -> in_full[2]=1 after the 16th; 17th dropped; pop yields exactly 16 words; with ERR_EN, err=1.
REQ-041 FIFO1 full, in_write tag 1 and out_read[1] in the same cycle -> write dropped; occupancy goes to 15.
REQ-042 Interleave tags 3,0,3,0 with cfg size 2 on both flows -> done[3] and done[0] pulse on their own 2nd pixel; data ordered per flow.
REQ-043 cfg flow0 size 8; write 3 pixels; rst high 1 cycle -> out_empty=4'b1111, no done, count 0; a subsequent tag-0 write without cfg is buffered and not counted; with ERR_EN, err=1.
REQ-044 Re-cfg flow1 size 5 after 2 pixels of a size-5 frame -> done[1] only after 5 further accepted pixels.
